// File: rtl/serial_frame_receiver_if.sv
// Output handshake bundle of serial_frame_receiver: word, valid and ready.
interface serial_frame_receiver_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] data_out;
    logic             data_valid;
    logic             data_ready;

    modport master (output data_out, output data_valid, input data_ready);
    modport slave  (input data_out, input data_valid, output data_ready);
endinterface

// File: rtl/serial_frame_receiver.sv
// Framed serial-to-parallel receiver with a one-entry valid/ready output buffer.
// Define SERIAL_FRAME_RECEIVER_PARITY_EN to add an even-parity bit between data and stop.
//
// state    | meaning
// S_IDLE   | line idle, waiting for a 0
// S_START  | confirming start bit at mid-bit
// S_DATA   | sampling WIDTH data bits
// S_PARITY | sampling the parity bit (parity build only)
// S_STOP   | sampling stop bit, delivering the word
module serial_frame_receiver #(
    parameter int WIDTH        = 4,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic                    clk,
    input  logic                    clear,
    input  logic                    serial_in_i,
    input  logic                    msb_first_i,
    serial_frame_receiver_if.master out_if,
    output logic                    busy_o,
    output logic                    frame_error_o,
    output logic                    parity_error_o,
    output logic                    overrun_o
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t           state_q;
    logic [CW-1:0]    cnt_q;
    logic [IW-1:0]    idx_q;
    logic             msb_q;
    logic [WIDTH-1:0] shift_q;
    logic [WIDTH-1:0] shift_d;
    logic [WIDTH-1:0] data_q;
    logic             valid_q;
    logic             ferr_q;
    logic             ovr_q;
    logic             stop_ok;
`ifdef SERIAL_FRAME_RECEIVER_PARITY_EN
    logic             par_bad_q;
    logic             perr_q;
`endif

    always_comb begin
        shift_d = shift_q;
        if (msb_q) begin
            shift_d = {shift_q[WIDTH-2:0], serial_in_i};
        end else begin
            shift_d = {serial_in_i, shift_q[WIDTH-1:1]};
        end
    end

`ifdef SERIAL_FRAME_RECEIVER_PARITY_EN
    assign stop_ok = serial_in_i & ~par_bad_q;
`else
    assign stop_ok = serial_in_i;
`endif

    always_ff @(posedge clk) begin
        if (!clear) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            msb_q   <= 1'b0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
`ifdef SERIAL_FRAME_RECEIVER_PARITY_EN
            par_bad_q <= 1'b0;
            perr_q    <= 1'b0;
`endif
        end else begin
            ferr_q <= 1'b0;
`ifdef SERIAL_FRAME_RECEIVER_PARITY_EN
            perr_q <= 1'b0;
`endif
            if (valid_q && out_if.data_ready) begin
                valid_q <= 1'b0;
            end
            case (state_q)
                S_IDLE: begin
                    if (!serial_in_i) begin
                        state_q <= S_START;
                        cnt_q   <= '0;
                    end
                end
                S_START: begin
                    if (cnt_q == CNT_HALF) begin
                        if (!serial_in_i) begin
                            state_q <= S_DATA;
                            cnt_q   <= '0;
                            idx_q   <= '0;
                            msb_q   <= msb_first_i;
                        end else begin
                            state_q <= S_IDLE;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_DATA: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_q   <= '0;
                        shift_q <= shift_d;
                        if (idx_q == IDX_LAST) begin
`ifdef SERIAL_FRAME_RECEIVER_PARITY_EN
                            state_q <= S_PARITY;
`else
                            state_q <= S_STOP;
`endif
                        end else begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
`ifdef SERIAL_FRAME_RECEIVER_PARITY_EN
                S_PARITY: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_q     <= '0;
                        par_bad_q <= serial_in_i ^ (^shift_q);
                        state_q   <= S_STOP;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
`endif
                S_STOP: begin
                    if (cnt_q == CNT_LAST) begin
                        state_q <= S_IDLE;
                        cnt_q   <= '0;
                        ferr_q  <= ~serial_in_i;
`ifdef SERIAL_FRAME_RECEIVER_PARITY_EN
                        perr_q  <= par_bad_q;
`endif
                        // a full buffer only takes the new word if it is draining this cycle
                        if (stop_ok) begin
                            if (!valid_q || out_if.data_ready) begin
                                data_q  <= shift_q;
                                valid_q <= 1'b1;
                            end else begin
                                ovr_q <= 1'b1;
                            end
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign out_if.data_out   = data_q;
    assign out_if.data_valid = valid_q;
    assign busy_o            = (state_q != S_IDLE);
    assign frame_error_o     = ferr_q;
    assign overrun_o         = ovr_q;
`ifdef SERIAL_FRAME_RECEIVER_PARITY_EN
    assign parity_error_o    = perr_q;
`else
    assign parity_error_o    = 1'b0;
`endif
endmodule

// File: tb/tb_serial_frame_receiver.sv
// Scoreboard bench for serial_frame_receiver: frame-level reference model, directed then random frames.
module tb_serial_frame_receiver;
    localparam int W = 4;
    localparam int C = 4;
    localparam int H = C / 2;
`ifdef SERIAL_FRAME_RECEIVER_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    localparam int LAT = H + (W + 1 + PB) * C;

    logic clk = 1'b0;
    logic clear = 1'b0;
    logic serial_in = 1'b1;
    logic msb_first = 1'b0;
    logic busy, ferr, perr, ovr;

    serial_frame_receiver_if #(.WIDTH(W)) bus ();

    serial_frame_receiver #(.WIDTH(W), .CLKS_PER_BIT(C)) dut (
        .clk            (clk),
        .clear          (clear),
        .serial_in_i    (serial_in),
        .msb_first_i    (msb_first),
        .out_if         (bus),
        .busy_o         (busy),
        .frame_error_o  (ferr),
        .parity_error_o (perr),
        .overrun_o      (ovr)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    bit chk_en = 0;
    bit rdy_rand = 0;

    logic [W-1:0] exp_q[$];
    bit model_full = 0, exp_ovr = 0, exp_busy = 0, exp_ferr = 0, exp_perr = 0;
    bit pend_valid = 0, pend_glitch = 0, pend_stop_ok = 0, pend_par_ok = 0;
    int pend_start = 0, pend_end = 0;
    logic [W-1:0] pend_word = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Frame-level reference: only start/end edges of each frame and the buffer occupancy.
    always @(posedge clk) begin
        bit hs;
        cyc++;
        exp_ferr = 0;
        exp_perr = 0;
        if (!clear) begin
            model_full = 0;
            exp_q.delete();
            exp_ovr = 0;
            exp_busy = 0;
            pend_valid = 0;
        end else begin
            hs = model_full && bus.data_ready;
            if (pend_valid && cyc == pend_start) exp_busy = 1;
            if (pend_valid && cyc == pend_end) begin
                exp_busy = 0;
                pend_valid = 0;
                if (!pend_glitch) begin
                    exp_ferr = !pend_stop_ok;
                    exp_perr = !pend_par_ok;
                    if (pend_stop_ok && pend_par_ok) begin
                        if (!model_full || bus.data_ready) begin
                            exp_q.push_back(pend_word);
                            model_full = 1;
                            hs = 0;
                        end else begin
                            exp_ovr = 1;
                        end
                    end
                end
            end
            if (hs) model_full = 0;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("data_valid", bus.data_valid, model_full);
            chk("overrun", ovr, exp_ovr);
            chk("busy", busy, exp_busy);
            chk("frame_error", ferr, exp_ferr);
            chk("parity_error", perr, exp_perr);
            if (model_full) begin
                chk("sb_depth", exp_q.size(), 1);
                if (exp_q.size() > 0) begin
                    chk("data_out", bus.data_out, exp_q[0]);
                    if (bus.data_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (rdy_rand) bus.data_ready = 1'($urandom_range(0, 1));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        serial_in = 1'b1;
        repeat (n) tick();
    endtask

    task automatic send(input logic [W-1:0] w, input bit msb, input bit stop, input bit par_flip,
                        input int stop_len, input int abort_at, input bit toggle_msb);
        logic b[$];
        int n;
        repeat (C) b.push_back(1'b0);
        for (int i = 0; i < W; i++) repeat (C) b.push_back(msb ? w[W-1-i] : w[i]);
        if (PB == 1) repeat (C) b.push_back((^w) ^ par_flip);
        n = stop ? stop_len : H + 1;
        repeat (n) b.push_back(stop);
        msb_first = msb;
        pend_word = w;
        pend_stop_ok = stop;
        pend_par_ok = (PB == 0) || !par_flip;
        pend_glitch = 0;
        pend_start = cyc + 1;
        pend_end = pend_start + LAT;
        pend_valid = 1;
        foreach (b[i]) begin
            if (i == abort_at) begin
                clear = 1'b0;
                serial_in = 1'b1;
                tick();
                tick();
                clear = 1'b1;
                return;
            end
            serial_in = b[i];
            if (toggle_msb && i > H) msb_first = 1'($urandom_range(0, 1));
            tick();
        end
        serial_in = 1'b1;
    endtask

    task automatic glitch();
        pend_glitch = 1;
        pend_start = cyc + 1;
        pend_end = pend_start + H;
        pend_valid = 1;
        serial_in = 1'b0;
        tick();
        idle(H + 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] w;
        bit stop, flip;
        bus.data_ready = 1'b0;
        clear = 1'b0;
        serial_in = 1'b0;
        tick();
        chk_en = 1;
        serial_in = 1'b1;
        tick();
        serial_in = 1'b0;
        tick();
        clear = 1'b1;
        serial_in = 1'b1;
        idle(3);
        chk("data_out_reset", bus.data_out, 0);

        bus.data_ready = 1'b1;
        send(4'b1100, 0, 1, 0, C, -1, 0);
        idle(2);
        send(4'b0011, 1, 1, 0, C, -1, 0);
        idle(2);
        send(4'b1100, 0, 0, 0, C, -1, 0);
        idle(3);

        bus.data_ready = 1'b0;
        send(4'b1100, 0, 1, 0, H + 1, -1, 0);
        send(4'b1010, 0, 1, 0, C, -1, 0);
        idle(2);
        bus.data_ready = 1'b1;
        tick();
        bus.data_ready = 1'b0;
        idle(2);
        bus.data_ready = 1'b1;

        glitch();
        idle(2);
        send(4'b0110, 0, 1, 0, C, 3 * C, 0);
        chk("data_out_abort", bus.data_out, 0);
        idle(2);
        if (PB == 1) begin
            send(4'b1100, 0, 1, 1, C, -1, 0);
            idle(2);
            send(4'b1001, 1, 0, 1, C, -1, 0);
            idle(2);
        end

        rdy_rand = 1;
        repeat (150) begin
            w = W'($urandom);
            stop = ($urandom_range(0, 7) != 0);
            flip = (PB == 1) && ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 29) == 0)
                send(w, 1'($urandom_range(0, 1)), stop, flip, C, $urandom_range(C, (W + 1) * C), 1);
            else
                send(w, 1'($urandom_range(0, 1)), stop, flip, $urandom_range(H + 1, C), -1, 1);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 4));
            if ($urandom_range(0, 19) == 0) glitch();
        end

        rdy_rand = 0;
        bus.data_ready = 1'b1;
        idle(4);
        chk("sb_drain", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
